mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_starve_cnt.sv | 33 +++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Owner encoding identifies which requester the in-flight access belongs to.
package mem_arb_pkg;

   localparam int STARVE_MAX_DEFAULT = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   typedef enum logic {
      TAG_IDLE = 1'b0,
      TAG_RESP = 1'b1
   } tag_state_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles a requester is denied; raises starved once the
// count reaches STARVE_MAX, where it holds until the requester is served.
module arb_starve_cnt
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic gnt,
   output logic starved
);

   localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

   logic [3:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (req && !gnt) begin
         if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 4'd1;
         end
      end else begin
         cnt_reg <= '0;
      end
   end

   assign starved = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous RAM.
// Data wins contention unless fetch has been starved; responses return 1 cycle later.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wd,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   logic       starved;
   tag_state_e state_reg, state_next;
   owner_e     owner_reg, owner_next;
   logic       write_reg, write_next;

   arb_starve_cnt #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (if_req),
      .gnt     (if_gnt),
      .starved (starved)
   );

   // Grant depends only on requests and registered starvation state, never on mem_rd.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst_n) begin
         if (if_req && (!d_req || starved)) begin
            if_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en   = if_gnt | d_gnt;
      mem_we   = d_gnt & d_we;
      mem_addr = '0;
      mem_wd   = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr = d_addr;
         mem_wd   = d_wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= TAG_IDLE;
         owner_reg <= OWN_NONE;
         write_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         owner_reg <= owner_next;
         write_reg <= write_next;
      end
   end

   always_comb begin
      state_next = TAG_IDLE;
      owner_next = OWN_NONE;
      write_next = 1'b0;
      if (if_gnt) begin
         state_next = TAG_RESP;
         owner_next = OWN_IF;
      end else if (d_gnt) begin
         state_next = TAG_RESP;
         owner_next = OWN_D;
         write_next = d_we;
      end
   end

   always_comb begin
      if_rvalid = (state_reg == TAG_RESP) && (owner_reg == OWN_IF);
      d_rvalid  = (state_reg == TAG_RESP) && (owner_reg == OWN_D);
      if_rdata  = if_rvalid ? mem_rd : '0;
      d_rdata   = (d_rvalid && !write_reg) ? mem_rd : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_mem_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wd = '0;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wd;
   logic [31:0] mem_rd = '0;

   int checks = 0;
   int failures = 0;

   // behavioural model state
   int  m_starve = 0;
   bit  m_resp_v = 0;
   int  m_resp_own = 0;   // 1 = fetch, 2 = data
   bit  m_resp_we = 0;
   bit  m_last_if = 0;
   bit  m_last_d = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(SM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wd      (d_wd),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   // One cycle: drive inputs after the falling edge, compare all outputs
   // against the model, then advance the model to the next rising edge.
   task automatic step(input bit rn, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [31:0] mr);
      bit e_if, e_d, e_ifv, e_dv;
      logic [31:0] e_addr, e_wd, e_ifd, e_dd;
      @(negedge clk);
      rst_n = rn; if_req = ir; if_addr = ia;
      d_req = dr; d_we = dw; d_addr = da; d_wd = dwd; mem_rd = mr;
      #1;
      e_if   = rn && ir && (!dr || m_starve >= SM);
      e_d    = rn && dr && !e_if;
      e_addr = e_if ? ia : (e_d ? da : 32'd0);
      e_wd   = e_d ? dwd : 32'd0;
      e_ifv  = rn && m_resp_v && (m_resp_own == 1);
      e_dv   = rn && m_resp_v && (m_resp_own == 2);
      e_ifd  = e_ifv ? mr : 32'd0;
      e_dd   = (e_dv && !m_resp_we) ? mr : 32'd0;
      chk1("if_gnt", if_gnt, e_if);
      chk1("d_gnt", d_gnt, e_d);
      chk1("mem_en", mem_en, e_if || e_d);
      chk1("mem_we", mem_we, e_d && dw);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wd", mem_wd, e_wd);
      chk1("if_rvalid", if_rvalid, e_ifv);
      chk1("d_rvalid", d_rvalid, e_dv);
      check("if_rdata", if_rdata, e_ifd);
      check("d_rdata", d_rdata, e_dd);
      if (!rn) begin
         m_starve = 0;
         m_resp_v = 0;
      end else begin
         m_starve   = (ir && !e_if) ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
         m_resp_v   = e_if || e_d;
         m_resp_own = e_if ? 1 : 2;
         m_resp_we  = e_d && dw;
      end
      m_last_if = e_if;
      m_last_d  = e_d;
   endtask

   initial begin
      bit ip, dp, dwv, rn;
      logic [31:0] ia, da, dwd;

      // reset state, requests present but grants suppressed
      step(0, 1, 32'h1234, 1, 0, 32'h40, 32'h0, 32'h55);
      chk1("rst_no_mem_en", mem_en, 1'b0);
      step(0, 1, 32'h1234, 1, 0, 32'h40, 32'h0, 32'h55);
      chk1("rst_if_rvalid", if_rvalid, 1'b0);
      check("rst_d_rdata", d_rdata, 32'h0);

      // fetch read: grant, then data one cycle later
      step(1, 1, 32'h8000_0000, 0, 0, 0, 0, 32'h0);
      chk1("fetch_gnt", if_gnt, 1'b1);
      check("fetch_addr", mem_addr, 32'h8000_0000);
      step(1, 0, 0, 0, 0, 0, 0, 32'h0000_0013);
      chk1("fetch_rvalid", if_rvalid, 1'b1);
      check("fetch_rdata", if_rdata, 32'h0000_0013);

      // data write: completion carries zero data
      step(1, 0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h0);
      chk1("wr_mem_we", mem_we, 1'b1);
      check("wr_mem_wd", mem_wd, 32'hDEAD_BEEF);
      step(1, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
      chk1("wr_rvalid", d_rvalid, 1'b1);
      check("wr_rdata", d_rdata, 32'h0);

      // continuous contention: four data grants, then one fetch grant
      for (int k = 0; k < 10; k++) begin
         step(1, 1, 32'h2000, 1, 0, 32'h3000, 0, 32'(k));
         chk1("contend_if_gnt", if_gnt, (k % 5) == 4);
         chk1("contend_d_gnt", d_gnt, (k % 5) != 4);
      end
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);

      // alternating fetch/data reads back-to-back
      for (int k = 0; k < 6; k++) begin
         step(1, (k % 2) == 0, 32'h10 + 32'(k), (k % 2) == 1, 0, 32'h20 + 32'(k), 0,
              32'hA000_0000 + 32'(k));
         chk1("alt_mem_en", mem_en, 1'b1);
         if (k > 0) begin
            chk1("alt_if_rvalid", if_rvalid, (k % 2) == 1);
            chk1("alt_d_rvalid", d_rvalid, (k % 2) == 0);
            check("alt_rdata", if_rdata | d_rdata, 32'hA000_0000 + 32'(k));
         end
      end
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);

      // reset right after a data read grant kills the response
      step(1, 0, 0, 1, 0, 32'h44, 0, 32'h0);
      chk1("prerst_d_gnt", d_gnt, 1'b1);
      step(0, 0, 0, 1, 0, 32'h48, 0, 32'h9999);
      chk1("rst_kill_rvalid", d_rvalid, 1'b0);
      step(1, 0, 0, 1, 0, 32'h48, 0, 32'h0);
      chk1("postrst_d_gnt", d_gnt, 1'b1);

      // fetch drop after 3 denials restarts the starvation count
      for (int k = 0; k < 3; k++) step(1, 1, 32'h500, 1, 0, 32'h600, 0, 32'h0);
      step(1, 0, 0, 1, 0, 32'h600, 0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(1, 1, 32'h500, 1, 0, 32'h600, 0, 32'h0);
         chk1("restart_if_gnt", if_gnt, k == 4);
      end
      step(1, 0, 0, 0, 0, 0, 0, 32'h0);

      // randomized traffic obeying the hold-until-grant protocol
      ip = 0; dp = 0; dwv = 0; ia = '0; da = '0; dwd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!ip && $urandom_range(0, 9) < 6) begin
            ip = 1; ia = $urandom;
         end
         if (!dp && $urandom_range(0, 9) < 6) begin
            dp = 1; dwv = 1'($urandom_range(0, 1)); da = $urandom; dwd = $urandom;
         end
         rn = ($urandom_range(0, 199) != 0);
         step(rn, ip, ia, dp, dwv, da, dwd, $urandom);
         if (m_last_if) ip = 0;
         if (m_last_d) dp = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
